// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: field widths, the expansion/permutation index
// table and the round-key selection rule.
package sdes_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    // Source bit of the 4-bit right half for each EP output bit, indexed by
    // output bit position (element 7 is the MSB). With r1 = bit 3 and
    // r4 = bit 0, this yields EP = r4 r1 r2 r3 r2 r3 r4 r1.
    localparam logic [1:0] EP_IDX [BYTE_W] = '{2'd3, 2'd0, 2'd1, 2'd2,
                                               2'd1, 2'd2, 2'd3, 2'd0};

    // One buffered result: the mixed byte plus the round tag travelling with it.
    typedef struct packed {
        logic              round;
        logic [BYTE_W-1:0] mix;
    } ep_entry_t;

    // Decryption runs the rounds with the subkeys swapped, so the key choice
    // collapses to round XOR decrypt.
    function automatic logic [BYTE_W-1:0] key_select(
        input logic              round,
        input logic              decrypt,
        input logic [BYTE_W-1:0] k1,
        input logic [BYTE_W-1:0] k2
    );
        return (round ^ decrypt) ? k2 : k1;
    endfunction

endpackage

// File: rtl/sdes_ep_xor.sv
// Expansion/permutation of the right half followed by the subkey XOR.
// Purely combinational; split out so the bit mapping lives in one place.
module sdes_ep_xor
    import sdes_pkg::*;
(
    input  logic [NIB_W-1:0]  right,
    input  logic [BYTE_W-1:0] key,
    output logic [NIB_W-1:0]  s0_nibble,
    output logic [NIB_W-1:0]  s1_nibble
);

    logic [BYTE_W-1:0] ep;
    logic [BYTE_W-1:0] mix;

    // Wire each EP output bit to its source bit in the right half.
    for (genvar g = 0; g < BYTE_W; g++) begin : g_ep
        assign ep[g] = right[EP_IDX[g]];
    end

    // Key mix and split into the two S-box inputs.
    always_comb begin
        mix       = ep ^ key;
        s0_nibble = mix[BYTE_W-1:NIB_W];
        s1_nibble = mix[NIB_W-1:0];
    end

endmodule

// File: rtl/sdes_ep_mix_stage.sv
// S-DES EP/key-mix pipeline stage: computes the S-box inputs at acceptance
// and queues them in a small FIFO toward the S-box consumer. Intake is held
// off until keys have been loaded once after reset.
module sdes_ep_mix_stage
    import sdes_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [BYTE_W-1:0] k1_in,
    input  logic [BYTE_W-1:0] k2_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_right,
    input  logic              in_round,
    input  logic              in_decrypt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  s0_nibble,
    output logic [NIB_W-1:0]  s1_nibble,
    output logic              out_round
);

    // DEPTH is 2 or 4, so the pointers wrap naturally at their width.
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = 3;

    logic [BYTE_W-1:0] k1_q, k1_d;
    logic [BYTE_W-1:0] k2_q, k2_d;
    logic              keys_loaded_q, keys_loaded_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    ep_entry_t         mem_q [DEPTH];
    ep_entry_t         mem_d [DEPTH];

    logic              push;
    logic              pop;
    logic [BYTE_W-1:0] sel_key;
    logic [NIB_W-1:0]  new_s0;
    logic [NIB_W-1:0]  new_s1;
    ep_entry_t         head;

    // Key chosen from the registered keys, so a same-cycle key_load does not
    // affect the entry being accepted.
    always_comb begin
        sel_key = key_select(in_round, in_decrypt, k1_q, k2_q);
    end

    sdes_ep_xor u_ep_xor (
        .right     (in_right),
        .key       (sel_key),
        .s0_nibble (new_s0),
        .s1_nibble (new_s1)
    );

    // Handshake and head-of-queue presentation; data is zeroed when empty.
    always_comb begin
        out_valid = (count_q != '0);
        in_ready  = keys_loaded_q && (count_q < CNT_W'(DEPTH));
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        head      = mem_q[rd_ptr_q];
        s0_nibble = out_valid ? head.mix[BYTE_W-1:NIB_W] : '0;
        s1_nibble = out_valid ? head.mix[NIB_W-1:0]      : '0;
        out_round = out_valid ? head.round               : 1'b0;
    end

    // Next-state for keys, FIFO storage, pointers and occupancy.
    always_comb begin
        k1_d          = k1_q;
        k2_d          = k2_q;
        keys_loaded_d = keys_loaded_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (key_load) begin
            k1_d          = k1_in;
            k2_d          = k2_in;
            keys_loaded_d = 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{round: in_round, mix: {new_s0, new_s1}};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wins over key loads and any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            k1_q          <= '0;
            k2_q          <= '0;
            keys_loaded_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            k1_q          <= k1_d;
            k2_q          <= k2_d;
            keys_loaded_q <= keys_loaded_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

endmodule

// File: tb/tb_sdes_ep_mix_stage.sv
// Directed bench for the EP/key-mix stage at DEPTH=2.
// Hand-derived EP values: EP(1010)=8'h55, EP(0001)=8'h82, EP(0110)=8'h3C.
module tb_sdes_ep_mix_stage;

    logic       clk;
    logic       rst;
    logic       key_load;
    logic [7:0] k1_in;
    logic [7:0] k2_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_right;
    logic       in_round;
    logic       in_decrypt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] s0_nibble;
    logic [3:0] s1_nibble;
    logic       out_round;

    int total = 0;
    int bad   = 0;

    sdes_ep_mix_stage #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .k1_in      (k1_in),
        .k2_in      (k2_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_right   (in_right),
        .in_round   (in_round),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s0_nibble  (s0_nibble),
        .s1_nibble  (s1_nibble),
        .out_round  (out_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic rnd, input logic dec);
        in_right   = r;
        in_round   = rnd;
        in_decrypt = dec;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if ({s0_nibble, s1_nibble, out_round} !== 9'h0)
            begin bad++; $display("FAIL rst_data got=%h/%h/%b exp=0/0/0", s0_nibble, s1_nibble, out_round); end
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_no_key();
        in_right = 4'b1010; in_round = 1'b0; in_decrypt = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL nokey_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nokey_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        k1_in = 8'hFF; k2_in = 8'h00; key_load = 1'b1;
        step();
        key_load = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        push(4'b1010, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        total++; if ({s0_nibble, s1_nibble, out_round} !== {8'hAA, 1'b0})
            begin bad++; $display("FAIL basic_data got=%h%h/%b exp=aa/0", s0_nibble, s1_nibble, out_round); end
        pop();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_key_sel();
        push(4'b0001, 1'b1, 1'b0);   // K2=00: 82
        total++; if ({s0_nibble, s1_nibble, out_round} !== {8'h82, 1'b1})
            begin bad++; $display("FAIL ksel_r1_enc got=%h%h/%b exp=82/1", s0_nibble, s1_nibble, out_round); end
        pop();
        push(4'b0001, 1'b1, 1'b1);   // K1=FF: 7D
        total++; if ({s0_nibble, s1_nibble, out_round} !== {8'h7D, 1'b1})
            begin bad++; $display("FAIL ksel_r1_dec got=%h%h/%b exp=7d/1", s0_nibble, s1_nibble, out_round); end
        pop();
        push(4'b1010, 1'b0, 1'b1);   // K2=00: 55
        total++; if ({s0_nibble, s1_nibble, out_round} !== {8'h55, 1'b0})
            begin bad++; $display("FAIL ksel_r0_dec got=%h%h/%b exp=55/0", s0_nibble, s1_nibble, out_round); end
        pop();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(4'b1010, 1'b0, 1'b0);   // AA
        push(4'b0001, 1'b1, 1'b0);   // 82
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        in_right = 4'b0110; in_round = 1'b0; in_decrypt = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({out_valid, s0_nibble, s1_nibble, out_round} !== {1'b1, 8'hAA, 1'b0})
                begin bad++; $display("FAIL bp_stable cyc=%0d got=%b/%h%h/%b exp=1/aa/0", i, out_valid, s0_nibble, s1_nibble, out_round); end
        end
        in_valid = 1'b0;
        pop();
        total++; if ({out_valid, s0_nibble, s1_nibble, out_round} !== {1'b1, 8'h82, 1'b1})
            begin bad++; $display("FAIL bp_order got=%b/%h%h/%b exp=1/82/1", out_valid, s0_nibble, s1_nibble, out_round); end
        pop();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        push(4'b1010, 1'b0, 1'b0);   // AA
        push(4'b0001, 1'b1, 1'b0);   // 82
        in_right = 4'b0110; in_round = 1'b0; in_decrypt = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if ({out_valid, in_ready, s0_nibble, s1_nibble} !== {2'b11, 8'h82})
            begin bad++; $display("FAIL full_pp got=%b%b/%h%h exp=11/82", out_valid, in_ready, s0_nibble, s1_nibble); end
        pop();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_pp_no_push got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_right = 4'b1010; in_round = 1'b0; in_decrypt = 1'b0;
        step();
        total++; if ({out_valid, s0_nibble, s1_nibble} !== {1'b1, 8'hAA})
            begin bad++; $display("FAIL b2b_0 got=%b/%h%h exp=1/aa", out_valid, s0_nibble, s1_nibble); end
        in_right = 4'b0001; in_round = 1'b1;
        step();
        total++; if ({out_valid, s0_nibble, s1_nibble, out_round} !== {1'b1, 8'h82, 1'b1})
            begin bad++; $display("FAIL b2b_1 got=%b/%h%h/%b exp=1/82/1", out_valid, s0_nibble, s1_nibble, out_round); end
        in_right = 4'b0110; in_round = 1'b0;
        step();
        total++; if ({out_valid, s0_nibble, s1_nibble, out_round} !== {1'b1, 8'hC3, 1'b0})
            begin bad++; $display("FAIL b2b_2 got=%b/%h%h/%b exp=1/c3/0", out_valid, s0_nibble, s1_nibble, out_round); end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_key_same_cycle();
        in_right = 4'b1010; in_round = 1'b0; in_decrypt = 1'b0;
        in_valid = 1'b1;
        k1_in = 8'h0F; k2_in = 8'hF0; key_load = 1'b1;
        step();                      // old K1=FF: AA
        key_load = 1'b0;
        step();                      // new K1=0F: 5A
        in_valid = 1'b0;
        total++; if ({s0_nibble, s1_nibble} !== 8'hAA)
            begin bad++; $display("FAIL ksame_old got=%h%h exp=aa", s0_nibble, s1_nibble); end
        pop();
        total++; if ({out_valid, s0_nibble, s1_nibble} !== {1'b1, 8'h5A})
            begin bad++; $display("FAIL ksame_new_k1 got=%b/%h%h exp=1/5a", out_valid, s0_nibble, s1_nibble); end
        pop();
        push(4'b1010, 1'b1, 1'b0);   // new K2=F0: A5
        total++; if ({s0_nibble, s1_nibble, out_round} !== {8'hA5, 1'b1})
            begin bad++; $display("FAIL ksame_new_k2 got=%h%h/%b exp=a5/1", s0_nibble, s1_nibble, out_round); end
        pop();
    endtask

    task automatic test_reset_flush();
        push(4'b1010, 1'b0, 1'b0);
        push(4'b0001, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", out_valid); end
        rst = 1'b1; key_load = 1'b1; k1_in = 8'hFF; k2_in = 8'h00;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if ({out_valid, in_ready, s0_nibble, s1_nibble, out_round} !== 11'h0)
            begin bad++; $display("FAIL flush_rst got=%b%b/%h%h/%b exp=00/00/0", out_valid, in_ready, s0_nibble, s1_nibble, out_round); end
        rst = 1'b0; key_load = 1'b0;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b00)
            begin bad++; $display("FAIL flush_reload got=%b%b exp=00", out_valid, in_ready); end
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_keyed got=%b exp=1", in_ready); end
        push(4'b1010, 1'b0, 1'b0);
        total++; if ({out_valid, s0_nibble, s1_nibble} !== {1'b1, 8'hAA})
            begin bad++; $display("FAIL flush_after got=%b/%h%h exp=1/aa", out_valid, s0_nibble, s1_nibble); end
        pop();
    endtask

    initial begin
        rst = 1'b1; key_load = 1'b0; k1_in = 8'h00; k2_in = 8'h00;
        in_valid = 1'b0; in_right = 4'h0; in_round = 1'b0; in_decrypt = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_no_key();
        test_basic();
        test_key_sel();
        test_backpressure();
        test_full_push_pop();
        test_back_to_back();
        test_key_same_cycle();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
